hazard_stall_ctrl: RTL

//  Produces the Stall/flush controls consumed by the PC, IF/ID and ID/EX pipeline registers.
//  - Detects load-use hazards and branch-operand hazards for the instruction in ID.
//  - Tracks the multi-cycle HI/LO (mult/div) unit with a busy counter.
//  - Squashes the IF/ID slot behind a taken branch.
//  - Sits beside the decode stage; its IDEXFlush output drives the ID/EX register reset input to insert bubbles.

---
 rtl/hazard_stall_ctrl_if.sv | 35 +++
 rtl/hazard_stall_ctrl.sv | 108 ++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl_if.sv
// Bundles the decode-side hazard inputs and the pipeline stall/flush outputs of hazard_stall_ctrl.
// master drives the ID/EX/MEM status fields; slave is the hazard controller itself.
interface hazard_stall_ctrl_if;
  logic [4:0]  IdRs;
  logic [4:0]  IdRt;
  logic        IdUsesRs;
  logic        IdUsesRt;
  logic        IdIsBranch;
  logic        IdUsesHILO;
  logic        BranchTaken;
  logic        ExMemRead;
  logic        ExRegWrite;
  logic [4:0]  ExWriteReg;
  logic        MemMemRead;
  logic [4:0]  MemWriteReg;
  logic        ExMulDivStart;
  logic        PCStall;
  logic        IFIDStall;
  logic        IFIDFlush;
  logic        IDEXFlush;
  logic        MulDivBusy;
  logic [31:0] StallCycles;

  modport master (
    output IdRs, IdRt, IdUsesRs, IdUsesRt, IdIsBranch, IdUsesHILO, BranchTaken,
           ExMemRead, ExRegWrite, ExWriteReg, MemMemRead, MemWriteReg, ExMulDivStart,
    input  PCStall, IFIDStall, IFIDFlush, IDEXFlush, MulDivBusy, StallCycles
  );

  modport slave (
    input  IdRs, IdRt, IdUsesRs, IdUsesRt, IdIsBranch, IdUsesHILO, BranchTaken,
           ExMemRead, ExRegWrite, ExWriteReg, MemMemRead, MemWriteReg, ExMulDivStart,
    output PCStall, IFIDStall, IFIDFlush, IDEXFlush, MulDivBusy, StallCycles
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Load-use / branch-operand / HI/LO interlock stall and flush controller for the ID stage.
// Optional stall-cycle statistics counter is built only when HAZ_STATS_EN is defined.
module hazard_stall_ctrl #(
  parameter int MULDIV_LAT = 32,
  parameter int CNT_W      = 8
) (
  input logic              i_clk,
  input logic              i_rst_n,
  hazard_stall_ctrl_if.slave hz
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LAT_RELOAD = CNT_W'(MULDIV_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  logic w_rs_ex;
  logic w_rt_ex;
  logic w_rs_mem;
  logic w_rt_mem;
  logic w_lu;
  logic w_br;
  logic w_hl;
  logic w_stall;

  // Register 0 is hardwired, so it can never be the source of a hazard.
  assign w_rs_ex  = hz.IdUsesRs && (hz.IdRs != 5'd0) && (hz.IdRs == hz.ExWriteReg);
  assign w_rt_ex  = hz.IdUsesRt && (hz.IdRt != 5'd0) && (hz.IdRt == hz.ExWriteReg);
  assign w_rs_mem = hz.IdUsesRs && (hz.IdRs != 5'd0) && (hz.IdRs == hz.MemWriteReg);
  assign w_rt_mem = hz.IdUsesRt && (hz.IdRt != 5'd0) && (hz.IdRt == hz.MemWriteReg);

  assign w_lu    = hz.ExMemRead && (w_rs_ex || w_rt_ex);
  assign w_br    = hz.IdIsBranch &&
                   ((hz.ExRegWrite && (w_rs_ex || w_rt_ex)) ||
                    (hz.MemMemRead && (w_rs_mem || w_rt_mem)));
  assign w_hl    = hz.IdUsesHILO && ((r_state == ST_BUSY) || hz.ExMulDivStart);
  assign w_stall = w_lu || w_br || w_hl;

  // A taken branch is only honoured once its operands are valid, i.e. when not stalled.
  assign hz.PCStall    = w_stall;
  assign hz.IFIDStall  = w_stall;
  assign hz.IDEXFlush  = w_stall;
  assign hz.IFIDFlush  = !w_stall && hz.BranchTaken && hz.IdIsBranch;
  assign hz.MulDivBusy = (r_state == ST_BUSY);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      ST_RUN: begin
        if (hz.ExMulDivStart) begin
          w_state_nxt = ST_BUSY;
          w_cnt_nxt   = LAT_RELOAD;
        end
      end
      ST_BUSY: begin
        // Re-issue while busy is blocked by the interlock; reload anyway to stay safe.
        if (hz.ExMulDivStart) begin
          w_cnt_nxt = LAT_RELOAD;
        end else if (r_cnt == CNT_ONE) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
        w_cnt_nxt   = '0;
      end
    endcase
  end

`ifdef HAZ_STATS_EN
  logic [31:0] r_stall_cycles;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stall_cycles <= 32'd0;
    end else if (w_stall) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign hz.StallCycles = r_stall_cycles;
`else
  assign hz.StallCycles = 32'd0;
`endif

endmodule
